// File: rtl/uart_alu_pkg.sv
// Shared state encoding and default widths for the UART ALU sequencer.
package uart_alu_pkg;

    localparam int SIZE_DATA_DEF = 8;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_LATCH   = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_SEND    = 3'd5,
        ST_WAIT_TX = 3'd6
    } state_t;

endpackage

// File: rtl/inter_byte_timer.sv
// Saturating idle-cycle counter that flags the last allowed idle cycle of a frame.
// Latency: o_terminal is combinational from the count register.
// Backpressure: none; counts while i_enable is high, i_clear wins over counting.
module inter_byte_timer #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_WIDTH      = 20
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    // A zero timeout parks the compare value at 0 and the compare itself is gated off.
    localparam logic [CNT_WIDTH-1:0] TERM =
        (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            cnt <= '0;
        end else if (i_enable && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_terminal = (TIMEOUT_CYCLES > 0) && (cnt == TERM);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects A, B and opcode bytes from the UART, latches them, then transmits the ALU result.
// Latency: latch_en 1 cycle and tx_start 3 cycles after the opcode byte's rx_done.
// Backpressure: bytes arriving while a result is in flight are dropped and flagged on o_drop.
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int SIZE_DATA      = SIZE_DATA_DEF,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_WIDTH      = 20
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [SIZE_DATA-1:0] i_rx_data,
    input  logic                 i_rx_done,
    input  logic [SIZE_DATA-1:0] i_alu_result,
    input  logic                 i_tx_done,
    output logic [SIZE_DATA-1:0] o_operandoA,
    output logic [SIZE_DATA-1:0] o_operandoB,
    output logic [SIZE_DATA-1:0] o_opcode,
    output logic                 o_latch_en,
    output logic [SIZE_DATA-1:0] o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_busy,
    output logic                 o_error,
    output logic                 o_drop
);

    state_t state, state_nxt;
    logic   accept;
    logic   timeout;
    logic   drop_nxt;
    logic   in_frame;
    logic   tmr_term;

    // The timer only runs between bytes of a partially received frame.
    assign in_frame = (state == ST_WAIT_B) || (state == ST_WAIT_OP);

    inter_byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (!in_frame || i_rx_done || timeout),
        .i_enable  (in_frame && !i_rx_done),
        .o_terminal(tmr_term)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        timeout   = 1'b0;
        drop_nxt  = 1'b0;
        case (state)
            ST_WAIT_A: begin
                if (i_rx_done) begin
                    accept    = 1'b1;
                    state_nxt = ST_WAIT_B;
                end
            end
            ST_WAIT_B, ST_WAIT_OP: begin
                // A byte on the terminal-count cycle takes priority over the timeout.
                if (i_rx_done) begin
                    accept    = 1'b1;
                    state_nxt = (state == ST_WAIT_B) ? ST_WAIT_OP : ST_LATCH;
                end else if (tmr_term) begin
                    timeout   = 1'b1;
                    state_nxt = ST_WAIT_A;
                end
            end
            ST_LATCH: begin
                drop_nxt  = i_rx_done;
                state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                drop_nxt  = i_rx_done;
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                drop_nxt  = i_rx_done;
                state_nxt = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                drop_nxt = i_rx_done;
                if (i_tx_done) begin
                    state_nxt = ST_WAIT_A;
                end
            end
            default: state_nxt = ST_WAIT_A;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_WAIT_A;
            o_operandoA <= '0;
            o_operandoB <= '0;
            o_opcode    <= '0;
            o_tx_data   <= '0;
            o_error     <= 1'b0;
            o_drop      <= 1'b0;
        end else begin
            state   <= state_nxt;
            o_error <= timeout;
            o_drop  <= drop_nxt;
            if (accept) begin
                case (state)
                    ST_WAIT_A:  o_operandoA <= i_rx_data;
                    ST_WAIT_B:  o_operandoB <= i_rx_data;
                    ST_WAIT_OP: o_opcode    <= i_rx_data;
                    default: ;
                endcase
            end
            if (state == ST_SETTLE) begin
                o_tx_data <= i_alu_result;
            end
        end
    end

    assign o_latch_en = (state == ST_LATCH);
    assign o_tx_start = (state == ST_SEND);
    assign o_busy     = (state != ST_WAIT_A);

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
Sequencer between the UART receiver, the operand/opcode latch bank and the UART transmitter. It collects three received bytes in order (operand A, operand B, opcode) and presents them on the latch-bank data inputs. It then pulses the single shared latch enable, waits one cycle for the combinational ALU result, and launches one UART transmission of that result. An inter-byte timeout discards an incomplete frame so the byte order cannot drift.

Parameters:
SIZE_DATA, 8, width of every data byte, operand, opcode and result
TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes of one frame; 0 disables the timeout
CNT_WIDTH, 20, width of the timeout counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_rx_data  in  SIZE_DATA  byte from UART receiver; valid when i_rx_done=1
i_rx_done  in  1  one-cycle pulse: new byte available
i_alu_result  in  SIZE_DATA  combinational ALU output fed from the latch bank
i_tx_done  in  1  one-cycle pulse: transmitter finished the current byte
o_operandoA  out  SIZE_DATA  captured operand A, to latch bank
o_operandoB  out  SIZE_DATA  captured operand B, to latch bank
o_opcode  out  SIZE_DATA  captured opcode, to latch bank
o_latch_en  out  1  one-cycle enable to the latch bank
o_tx_data  out  SIZE_DATA  result byte to transmit
o_tx_start  out  1  one-cycle start pulse to the transmitter
o_busy  out  1  high in every state except ST_WAIT_A
o_error  out  1  one-cycle pulse on inter-byte timeout
o_drop  out  1  one-cycle pulse when a received byte is ignored

Behaviour:
- Single clock. Reset is synchronous and active-high, on i_clk and i_reset. The reset polarity and synchronicity are fixed.
- Reset effects (take effect at the next rising edge with i_reset=1):
  - State goes to ST_WAIT_A.
  - o_operandoA, o_operandoB, o_opcode and o_tx_data are cleared to 0.
  - o_latch_en, o_tx_start, o_error, o_drop and o_busy are 0.
  - Timeout counter is cleared to 0.
  - Reset overrides everything, including mid-frame and mid-transmission. A transmission already handed off is not aborted by this block.
- States and transitions:
  - ST_WAIT_A: on i_rx_done, o_operandoA<=i_rx_data, go to ST_WAIT_B. No timeout in this state.
  - ST_WAIT_B: on i_rx_done, o_operandoB<=i_rx_data, go to ST_WAIT_OP.
  - ST_WAIT_OP: on i_rx_done, o_opcode<=i_rx_data, go to ST_LATCH.
  - ST_LATCH: o_latch_en=1 for exactly this cycle, then go to ST_SETTLE.
  - ST_SETTLE: i_alu_result is valid. At the end of the cycle, o_tx_data<=i_alu_result, then go to ST_SEND.
  - ST_SEND: o_tx_start=1 for exactly this cycle, then go to ST_WAIT_TX.
  - ST_WAIT_TX: on i_tx_done, go to ST_WAIT_A.
- Timing:
  - o_latch_en and o_tx_start are decoded from state (Moore).
  - Third-byte i_rx_done at cycle t gives o_latch_en at t+1 and o_tx_start at t+3.
  - o_tx_data is stable from t+3 until the next frame's ST_SETTLE.
- Timeout (only when TIMEOUT_CYCLES>0, only in ST_WAIT_B and ST_WAIT_OP):
  - The counter clears on every accepted byte and increments on each cycle without i_rx_done.
  - When the counter equals TIMEOUT_CYCLES-1 with no i_rx_done that cycle: o_error pulses next cycle, state goes to ST_WAIT_A, counter clears.
  - Already captured operand registers keep their values.
  - If i_rx_done coincides with the terminal count, the byte wins: it is accepted and no error is raised.
- Dropped bytes:
  - An i_rx_done in ST_LATCH, ST_SETTLE, ST_SEND or ST_WAIT_TX is ignored.
  - o_drop pulses on the next cycle; registers are unchanged.
- Stray pulses: i_tx_done outside ST_WAIT_TX is ignored.
- Simultaneous events: i_tx_done together with i_rx_done in ST_WAIT_TX returns to ST_WAIT_A, drops the byte and pulses o_drop.
- Width rules: all data paths are SIZE_DATA wide with no arithmetic. The counter saturates; it never wraps.

Decomposition:
- Package uart_alu_pkg:
  - State encoding constants ST_WAIT_A..ST_WAIT_TX (3 bits).
  - Default SIZE_DATA.
- One sub-module: inter_byte_timer.
  - Ports: clear, enable, terminal-count output.
  - Parameters: TIMEOUT_CYCLES, CNT_WIDTH.
- The FSM, operand registers and output decode stay in uart_alu_ctrl.

Test Plan:
- Nominal frame:
  - Stimulus: reset, then bytes 0x05, 0x03, 0x20 (ADD) spaced 10 cycles apart; model the ALU as A+B = 0x08.
  - Response: o_operandoA/o_operandoB/o_opcode = 05/03/20; one o_latch_en pulse 1 cycle after the third byte; o_tx_start 3 cycles after it with o_tx_data=0x08; o_busy drops after i_tx_done.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16; send 0xAA, then silence.
  - Response: o_error pulses exactly 16 cycles later; state back in ST_WAIT_A (o_busy=0); then 0x01, 0x02, 0x20 produce a result of 0x03.
- Timeout boundary:
  - Stimulus: second byte arrives on the terminal-count cycle.
  - Response: byte accepted, no o_error.
- Drop during transmit:
  - Stimulus: i_rx_done with 0x77 while in ST_WAIT_TX.
  - Response: o_drop pulse; operands unchanged; the next full frame is processed normally.
- Reset mid-frame:
  - Stimulus: assert i_reset for 1 cycle after byte B.
  - Response: all outputs 0, o_busy=0; the following three bytes form a complete new frame.
- Back-to-back frames:
  - Stimulus: the next frame's first byte arrives the cycle after i_tx_done.
  - Response: byte accepted as A; two consecutive results are transmitted correctly.
